window_frame_sequencer: RTL

Frame scheduler in front of the Hanning window unit. It accepts a continuous 16-bit sample stream and buffers it in a circular RAM. It then emits overlapping N-sample frames (hop HOP), each followed by NF−N zero-pad slots. Every emitted slot carries its coefficient index, so the window unit and the downstream FFT see exactly NF slots per frame with frame markers.

---
 rtl/window_pkg.sv | 26 ++
 rtl/window_frame_sequencer_if.sv | 28 ++
 rtl/window_frame_sequencer_frame_ring_ram.sv | 33 +++
 rtl/window_frame_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared constants, widths and state type for the window frame sequencer and window unit.
// FRAME_OVERLAP_EN selects overlapping frames (hop = HOP); otherwise frames are disjoint (hop = N).
package window_pkg;

    localparam int N     = 256;
    localparam int NF    = 512;
    localparam int HOP   = 128;
    localparam int W     = 16;
    localparam int Q     = 15;

    localparam int IDX_W = $clog2(NF);
    localparam int PTR_W = $clog2(N);

`ifdef FRAME_OVERLAP_EN
    localparam int HOP_EFF = HOP;
`else
    localparam int HOP_EFF = N;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        PAD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/window_frame_sequencer_if.sv
// Sample-in / slot-out stream bundle of the window frame sequencer.
// The sequencer uses the slave view; the producer/consumer side uses the master view.
interface window_frame_sequencer_if;
    import window_pkg::*;

    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;

    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_pad;
    logic             out_first;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_pad, out_first, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_pad, out_first, out_last, out_valid
    );

endinterface

// File: rtl/window_frame_sequencer_frame_ring_ram.sv
// N x W simple dual-port ring buffer: one write port, one synchronous read port.
// Only the read-data register is reset; the array itself carries no reset.
module frame_ring_ram
    import window_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the output data stage, so it only loads when a slot is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/window_frame_sequencer.sv
// Frame scheduler: buffers samples in a ring and emits N-sample frames zero-padded to NF slots.
// FRAME_OVERLAP_EN (see window_pkg) selects overlapping frames with hop HOP.
//
// state | meaning
// IDLE  | collecting samples until the ring holds N
// EMIT  | issuing the N buffered samples of the current frame
// PAD   | issuing the NF-N zero slots that close the frame
module window_frame_sequencer
    import window_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    window_frame_sequencer_if.slave bus,
    output logic [15:0]             frame_cnt
);

    localparam logic [PTR_W-1:0] HOP_PTR   = PTR_W'(HOP_EFF % N);
    localparam logic [PTR_W:0]   HOP_FILL  = (PTR_W + 1)'(HOP_EFF);
    localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NF - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;

    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] fb;
    logic [PTR_W:0]   fill;
    logic [PTR_W:0]   fill_nxt;
    logic [IDX_W-1:0] slot;

    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_pad;
    logic             out_first;
    logic             out_last;
    logic [W-1:0]     ram_q;
    logic [15:0]      frame_cnt_q;

    logic             in_fire;
    logic             out_fire;
    logic             adv;
    logic             frame_hop;
    logic             hold_last;
    logic             issue;
    logic             issue_pad;
    logic             rd_en;
    logic [PTR_W-1:0] rd_addr;

    assign bus.in_ready = rst_n & (fill < FULL);

    assign in_fire   = bus.in_valid & bus.in_ready;
    assign out_fire  = out_valid & bus.out_ready;
    assign adv       = ~out_valid | bus.out_ready;
    assign frame_hop = out_fire & ~out_pad & (out_idx == LAST_DATA);
    // Last data slot still waiting downstream: the ring is full but its base has not moved yet.
    assign hold_last = out_valid & ~bus.out_ready & ~out_pad & (out_idx == LAST_DATA);

    always_comb begin
        fill_nxt = fill + {{PTR_W{1'b0}}, in_fire};
        if (frame_hop) begin
            fill_nxt = fill_nxt - HOP_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if ((fill_nxt == FULL) && !hold_last) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (adv && (slot == LAST_DATA)) begin
                    state_nxt = (NF == N) ? IDLE : PAD;
                end
            end
            PAD: begin
                if (adv && (slot == LAST_SLOT)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue     = 1'b0;
        issue_pad = 1'b0;
        unique case (state)
            EMIT: begin
                issue = adv;
            end
            PAD: begin
                issue     = adv;
                issue_pad = 1'b1;
            end
            default: begin
                issue     = 1'b0;
                issue_pad = 1'b0;
            end
        endcase
    end

    assign rd_en   = issue & ~issue_pad;
    assign rd_addr = fb + slot[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp          <= '0;
            fb          <= '0;
            fill        <= '0;
            slot        <= '0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_pad     <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            fill <= fill_nxt;
            if (in_fire) begin
                wp <= wp + 1'b1;
            end
            if (frame_hop) begin
                fb <= fb + HOP_PTR;
            end
            if (adv) begin
                out_valid <= issue;
                if (issue) begin
                    out_idx   <= slot;
                    out_pad   <= issue_pad;
                    out_first <= (slot == '0);
                    out_last  <= (slot == LAST_SLOT);
                    slot      <= slot + 1'b1;
                end
            end
            if (out_fire && out_last) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    frame_ring_ram u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_fire),
        .waddr (wp),
        .wdata (bus.in_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.out_pad   = out_pad;
    assign bus.out_first = out_first;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_pad ? '0 : ram_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
